// File: rtl/nfc_cmd_sequencer_if.sv
// Host/flash-controller signal bundle for nfc_cmd_sequencer.
// The sequencer uses the slave modport; the host and controller side use master.
interface nfc_cmd_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int RWA_W = 16,
  parameter int TAG_W = 4
);
  logic                     cq_valid;
  logic                     cq_ready;
  logic [2:0]               cq_cmd;
  logic [RWA_W-1:0]         cq_addr;
  logic [TAG_W-1:0]         cq_tag;

  logic [2:0]               nfc_cmd;
  logic                     nfc_strt;
  logic [RWA_W-1:0]         RWA;
  logic                     nfc_done;
  logic                     PErr;
  logic                     EErr;
  logic                     RErr;

  logic                     st_valid;
  logic                     st_ready;
  logic [TAG_W-1:0]         st_tag;
  logic [2:0]               st_cmd;
  logic                     st_err;
  logic                     st_timeout;
  logic                     st_illegal;

  logic                     busy;
  logic [$clog2(DEPTH):0]   q_count;

  modport master (
    output cq_valid, cq_cmd, cq_addr, cq_tag, nfc_done, PErr, EErr, RErr, st_ready,
    input  cq_ready, nfc_cmd, nfc_strt, RWA, st_valid, st_tag, st_cmd, st_err,
           st_timeout, st_illegal, busy, q_count
  );

  modport slave (
    input  cq_valid, cq_cmd, cq_addr, cq_tag, nfc_done, PErr, EErr, RErr, st_ready,
    output cq_ready, nfc_cmd, nfc_strt, RWA, st_valid, st_tag, st_cmd, st_err,
           st_timeout, st_illegal, busy, q_count
  );
endinterface

// File: rtl/nfc_cmd_sequencer.sv
// NAND command sequencer: FIFO of host commands, issued one at a time to the flash
// controller, one status per command. Define NFC_SEQ_TIMEOUT_EN to build the timeout.
//   state     | meaning
//   IDLE      | waiting for a queued command
//   ISSUE     | one-cycle start pulse to the controller
//   ARM       | waiting for a stale nfc_done to drop
//   WAIT_DONE | waiting for the controller to finish
//   REPORT    | status held until the host accepts it
module nfc_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int RWA_W = 16,
  parameter int TAG_W = 4,
  parameter int TO_W  = 20
) (
  input  logic                clk,
  input  logic                rst,
  nfc_cmd_sequencer_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [2:0] OP_PROG    = 3'b001;
  localparam logic [2:0] OP_READ    = 3'b010;
  localparam logic [2:0] OP_RESET   = 3'b011;
  localparam logic [2:0] OP_ERASE   = 3'b100;
  localparam logic [2:0] OP_READ_ID = 3'b101;
  localparam logic [2:0] OP_NONE    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT_DONE, S_REPORT
  } state_t;

  typedef struct packed {
    logic [2:0]       cmd;
    logic [RWA_W-1:0] addr;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic f_legal(input logic [2:0] op);
    case (op)
      OP_PROG, OP_READ, OP_RESET, OP_ERASE, OP_READ_ID: f_legal = 1'b1;
      default:                                          f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f_err(input logic [2:0] op, input logic pe, input logic ee,
                                 input logic re);
    case (op)
      OP_PROG:  f_err = pe;
      OP_ERASE: f_err = ee;
      OP_READ:  f_err = re;
      default:  f_err = 1'b0;
    endcase
  endfunction

  state_t           r_state;
  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             r_nfc_strt;
  logic [2:0]       r_nfc_cmd;
  logic [RWA_W-1:0] r_rwa;
  logic             r_st_valid;
  logic [TAG_W-1:0] r_st_tag;
  logic [2:0]       r_st_cmd;
  logic             r_st_err;
  logic             r_st_timeout;
  logic             r_st_illegal;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_to_hit;
  entry_t           w_head;

  // Full is judged on the registered count only, so a same-cycle pop never reopens it.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cq_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.cq_cmd, bus.cq_addr, bus.cq_tag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef NFC_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  r_to_cnt <= '0;
    else if (r_state == S_ISSUE)                              r_to_cnt <= '0;
    else if (r_state == S_ARM || r_state == S_WAIT_DONE)      r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_to_hit = (r_state == S_ARM || r_state == S_WAIT_DONE) && (r_to_cnt == '1);
`else
  // No counter in this build; a zero-width limit never exists, so this is constant 0.
  assign w_to_hit = (TO_W == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_nfc_strt   <= 1'b0;
      r_nfc_cmd    <= OP_NONE;
      r_rwa        <= '0;
      r_st_valid   <= 1'b0;
      r_st_tag     <= '0;
      r_st_cmd     <= '0;
      r_st_err     <= 1'b0;
      r_st_timeout <= 1'b0;
      r_st_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_st_tag     <= w_head.tag;
            r_st_cmd     <= w_head.cmd;
            r_st_err     <= 1'b0;
            r_st_timeout <= 1'b0;
            if (f_legal(w_head.cmd)) begin
              r_st_illegal <= 1'b0;
              r_nfc_strt   <= 1'b1;
              r_nfc_cmd    <= w_head.cmd;
              r_rwa        <= w_head.addr;
              r_state      <= S_ISSUE;
            end else begin
              r_st_illegal <= 1'b1;
              r_st_valid   <= 1'b1;
              r_state      <= S_REPORT;
            end
          end
        end
        S_ISSUE: begin
          r_nfc_strt <= 1'b0;
          r_state    <= S_ARM;
        end
        S_ARM: begin
          if (w_to_hit) begin
            r_st_timeout <= 1'b1;
            r_st_valid   <= 1'b1;
            r_nfc_cmd    <= OP_NONE;
            r_state      <= S_REPORT;
          end else if (!bus.nfc_done) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.nfc_done) begin
            r_st_err   <= f_err(r_st_cmd, bus.PErr, bus.EErr, bus.RErr);
            r_st_valid <= 1'b1;
            r_nfc_cmd  <= OP_NONE;
            r_state    <= S_REPORT;
          end else if (w_to_hit) begin
            r_st_timeout <= 1'b1;
            r_st_valid   <= 1'b1;
            r_nfc_cmd    <= OP_NONE;
            r_state      <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (bus.st_ready) begin
            r_st_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cq_ready   = !w_full;
  assign bus.nfc_strt   = r_nfc_strt;
  assign bus.nfc_cmd    = r_nfc_cmd;
  assign bus.RWA        = r_rwa;
  assign bus.st_valid   = r_st_valid;
  assign bus.st_tag     = r_st_tag;
  assign bus.st_cmd     = r_st_cmd;
  assign bus.st_err     = r_st_err;
  assign bus.st_timeout = r_st_timeout;
  assign bus.st_illegal = r_st_illegal;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.q_count    = r_count;
endmodule

// File: tb/tb_nfc_cmd_sequencer.sv
// Directed bench for nfc_cmd_sequencer: a vector table of single commands plus
// hand sequences for queue-full, timeout (when NFC_SEQ_TIMEOUT_EN) and mid-op reset.
module tb_nfc_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int RWA_W = 16;
  localparam int TAG_W = 4;
  localparam int TO_W  = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nfc_cmd_sequencer_if #(.DEPTH(DEPTH), .RWA_W(RWA_W), .TAG_W(TAG_W)) bus ();

  nfc_cmd_sequencer #(.DEPTH(DEPTH), .RWA_W(RWA_W), .TAG_W(TAG_W), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [15:0] addr;
    logic [3:0]  tag;
    logic        perr;
    logic        eerr;
    logic        rerr;
    logic        illegal;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_q_count"},    32'(bus.q_count),    0);
    chk({tag, "_cq_ready"},   32'(bus.cq_ready),   1);
    chk({tag, "_nfc_strt"},   32'(bus.nfc_strt),   0);
    chk({tag, "_nfc_cmd"},    32'(bus.nfc_cmd),    7);
    chk({tag, "_RWA"},        32'(bus.RWA),        0);
    chk({tag, "_st_valid"},   32'(bus.st_valid),   0);
    chk({tag, "_st_tag"},     32'(bus.st_tag),     0);
    chk({tag, "_st_cmd"},     32'(bus.st_cmd),     0);
    chk({tag, "_st_err"},     32'(bus.st_err),     0);
    chk({tag, "_st_timeout"}, 32'(bus.st_timeout), 0);
    chk({tag, "_st_illegal"}, 32'(bus.st_illegal), 0);
    chk({tag, "_busy"},       32'(bus.busy),       0);
  endtask

  task automatic push(input logic [2:0] c, input logic [15:0] a, input logic [3:0] t);
    bus.cq_valid = 1'b1;
    bus.cq_cmd   = c;
    bus.cq_addr  = a;
    bus.cq_tag   = t;
    @(negedge clk);
    bus.cq_valid = 1'b0;
  endtask

  // Acts as host and controller until one status is popped or the budget runs out.
  task automatic get_status(input logic answer, output logic ok, output logic [3:0] tag,
                            output logic [2:0] cmd, output logic err, output logic tmo);
    int dly;
    dly = -1;
    ok  = 1'b0;
    tag = '0; cmd = '0; err = 1'b0; tmo = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      bus.nfc_done = 1'b0;
      if (bus.st_valid) begin
        ok  = 1'b1;
        tag = bus.st_tag;
        cmd = bus.st_cmd;
        err = bus.st_err;
        tmo = bus.st_timeout;
        bus.st_ready = 1'b1;
        @(negedge clk);
        bus.st_ready = 1'b0;
      end else if (bus.nfc_strt) begin
        dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0 && answer) bus.nfc_done = 1'b1;
      end
    end
  endtask

  logic       s_ok;
  logic [3:0] s_tag;
  logic [2:0] s_cmd;
  logic       s_err;
  logic       s_tmo;
  int         seen;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{3'b001, 16'h0012, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'b010, 16'h1234, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{3'b100, 16'hABCD, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{3'b001, 16'h0F0F, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{3'b011, 16'h0001, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{3'b101, 16'h8000, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{3'b110, 16'h5555, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{3'b000, 16'h0002, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{3'b111, 16'hFFFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{3'b001, 16'h7777, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.cq_valid = 1'b0; bus.cq_cmd = '0; bus.cq_addr = '0; bus.cq_tag = '0;
    bus.nfc_done = 1'b0; bus.PErr = 1'b0; bus.EErr = 1'b0; bus.RErr = 1'b0;
    bus.st_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      push(vecs[i].cmd, vecs[i].addr, vecs[i].tag);
      chk($sformatf("v%0d_strt_early", i), 32'(bus.nfc_strt), 0);
      @(negedge clk);
      if (vecs[i].illegal) begin
        chk($sformatf("v%0d_no_strt", i), 32'(bus.nfc_strt), 0);
        chk($sformatf("v%0d_cmd_idle", i), 32'(bus.nfc_cmd), 7);
      end else begin
        chk($sformatf("v%0d_strt", i), 32'(bus.nfc_strt), 1);
        chk($sformatf("v%0d_nfc_cmd", i), 32'(bus.nfc_cmd), 32'(vecs[i].cmd));
        chk($sformatf("v%0d_RWA", i), 32'(bus.RWA), 32'(vecs[i].addr));
        @(negedge clk);
        chk($sformatf("v%0d_strt_one", i), 32'(bus.nfc_strt), 0);
        @(negedge clk);
        chk($sformatf("v%0d_cmd_hold", i), 32'(bus.nfc_cmd), 32'(vecs[i].cmd));
        chk($sformatf("v%0d_RWA_hold", i), 32'(bus.RWA), 32'(vecs[i].addr));
        chk($sformatf("v%0d_no_status_yet", i), 32'(bus.st_valid), 0);
        bus.nfc_done = 1'b1;
        bus.PErr = vecs[i].perr; bus.EErr = vecs[i].eerr; bus.RErr = vecs[i].rerr;
        @(negedge clk);
        bus.nfc_done = 1'b0;
        bus.PErr = 1'b0; bus.EErr = 1'b0; bus.RErr = 1'b0;
      end
      chk($sformatf("v%0d_st_valid", i), 32'(bus.st_valid), 1);
      chk($sformatf("v%0d_st_tag", i), 32'(bus.st_tag), 32'(vecs[i].tag));
      chk($sformatf("v%0d_st_cmd", i), 32'(bus.st_cmd), 32'(vecs[i].cmd));
      chk($sformatf("v%0d_st_err", i), 32'(bus.st_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_st_illegal", i), 32'(bus.st_illegal), 32'(vecs[i].illegal));
      chk($sformatf("v%0d_st_timeout", i), 32'(bus.st_timeout), 0);
      chk($sformatf("v%0d_cmd_back", i), 32'(bus.nfc_cmd), 7);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 1);
      bus.st_ready = 1'b1;
      @(negedge clk);
      bus.st_ready = 1'b0;
      chk($sformatf("v%0d_st_popped", i), 32'(bus.st_valid), 0);
      chk($sformatf("v%0d_idle", i), 32'(bus.busy), 0);
    end

    // Queue full: a blocker holds the FSM in WAIT_DONE while the queue fills.
    push(3'b001, 16'h00AA, 4'd15);
    repeat (3) @(negedge clk);
    chk("full_blocker_busy", 32'(bus.busy), 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("full_ready_%0d", i), 32'(bus.cq_ready), 1);
      push(3'b001, 16'(i), 4'(i));
    end
    chk("full_count", 32'(bus.q_count), DEPTH);
    chk("full_ready_low", 32'(bus.cq_ready), 0);
    bus.cq_valid = 1'b1; bus.cq_cmd = 3'b001; bus.cq_tag = 4'(DEPTH);
    @(negedge clk);
    bus.cq_valid = 1'b0;
    chk("full_extra_rejected", 32'(bus.q_count), DEPTH);
    bus.nfc_done = 1'b1;
    get_status(1'b1, s_ok, s_tag, s_cmd, s_err, s_tmo);
    chk("full_blocker_ok", 32'(s_ok), 1);
    chk("full_blocker_tag", 32'(s_tag), 15);
    for (int i = 0; i < DEPTH; i++) begin
      get_status(1'b1, s_ok, s_tag, s_cmd, s_err, s_tmo);
      chk($sformatf("full_ok_%0d", i), 32'(s_ok), 1);
      chk($sformatf("full_tag_%0d", i), 32'(s_tag), i);
    end
    chk("full_drained", 32'(bus.q_count), 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.st_valid || bus.nfc_strt) seen++;
    end
    chk("full_no_extra_status", 32'(seen), 0);

`ifdef NFC_SEQ_TIMEOUT_EN
    push(3'b100, 16'h0BAD, 4'd4);
    push(3'b001, 16'h0C0C, 4'd5);
    get_status(1'b0, s_ok, s_tag, s_cmd, s_err, s_tmo);
    chk("to_ok", 32'(s_ok), 1);
    chk("to_tag", 32'(s_tag), 4);
    chk("to_cmd", 32'(s_cmd), 4);
    chk("to_timeout", 32'(s_tmo), 1);
    chk("to_err", 32'(s_err), 0);
    get_status(1'b1, s_ok, s_tag, s_cmd, s_err, s_tmo);
    chk("to_next_ok", 32'(s_ok), 1);
    chk("to_next_tag", 32'(s_tag), 5);
    chk("to_next_timeout", 32'(s_tmo), 0);
`endif

    // Reset in WAIT_DONE with two commands queued behind the active one.
    push(3'b010, 16'h4321, 4'd1);
    push(3'b001, 16'h0002, 4'd2);
    push(3'b100, 16'h0003, 4'd3);
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 1);
    chk("mid_count", 32'(bus.q_count), 2);
    chk("mid_cmd", 32'(bus.nfc_cmd), 2);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.st_valid || bus.nfc_strt || bus.busy) seen++;
    end
    chk("mid_no_status", 32'(seen), 0);
    chk("mid_count_after", 32'(bus.q_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
